// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline register feeding a combinational ALU. The stage decodes
//   opcode/funct into the 4-bit ALU_Func code and selects and extends the two
//   operands. It registers them behind a valid/ready handshake with one cycle
//   of latency. Illegal instructions are flagged, and saturating debug
//   counters track issued and illegal operations.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   valid_in / ready_in   upstream handshake (ready_in is combinational)
//   opcode, funct         instr[31:26], instr[5:0]
//   rs_data, rt_data      register-file operands
//   imm16                 instr[15:0]
//   flush                 synchronous squash of the output stage and input
//   valid_out / ready_out downstream handshake
//   In1, In2, ALU_Func    registered ALU operands and function code
//   illegal_op            one-cycle pulse on an accepted illegal instruction
//   issue_count           saturating count of downstream handshakes
//   illegal_count         saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [15:0]      imm16,
    input  logic             flush,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [31:0]      In1,
    output logic [31:0]      In2,
    output logic [3:0]       ALU_Func,
    output logic             illegal_op,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic        w_accept;
    logic        w_issue;
    logic        w_legal;
    logic [3:0]  w_func;
    logic [31:0] w_in1;
    logic [31:0] w_in2;
    logic [31:0] w_sext;
    logic [31:0] w_zext;

    assign ready_in = !valid_out || ready_out;
    assign w_accept = valid_in && ready_in;
    assign w_issue  = valid_out && ready_out;
    assign w_sext   = {{16{imm16[15]}}, imm16};
    assign w_zext   = {16'h0000, imm16};

    // Instruction decode: ALU function code, operand selection, legality.
    always_comb begin
        w_legal = 1'b1;
        w_func  = 4'b0000;
        w_in1   = rs_data;
        w_in2   = rt_data;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: w_func = 4'b0100;
                    6'h22, 6'h23: w_func = 4'b1100;
                    6'h24:        w_func = 4'b0000;
                    6'h25:        w_func = 4'b0001;
                    6'h26:        w_func = 4'b0010;
                    6'h2A:        w_func = 4'b1101;
                    default:      w_legal = 1'b0;
                endcase
            end
            // Branch compare is done as a subtract.
            6'h04, 6'h05: w_func = 4'b1100;
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                w_func = 4'b0100;
                w_in2  = w_sext;
            end
            6'h0A: begin
                w_func = 4'b1101;
                w_in2  = w_sext;
            end
            6'h0C: begin
                w_func = 4'b0000;
                w_in2  = w_zext;
            end
            6'h0D: begin
                w_func = 4'b0001;
                w_in2  = w_zext;
            end
            6'h0E: begin
                w_func = 4'b0010;
                w_in2  = w_zext;
            end
            // lui: 0 + (imm16 << 16).
            6'h0F: begin
                w_func = 4'b0100;
                w_in1  = 32'h0000_0000;
                w_in2  = {imm16, 16'h0000};
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Output stage register: flush beats accept, and accept beats hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out  <= 1'b0;
            In1        <= 32'h0000_0000;
            In2        <= 32'h0000_0000;
            ALU_Func   <= 4'b0000;
            illegal_op <= 1'b0;
        end else if (flush) begin
            valid_out  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                valid_out  <= 1'b1;
                In1        <= w_in1;
                In2        <= w_in2;
                ALU_Func   <= w_func;
                illegal_op <= 1'b0;
            end else begin
                // The illegal op is consumed here and never presented downstream.
                valid_out  <= 1'b0;
                In1        <= 32'h0000_0000;
                In2        <= 32'h0000_0000;
                ALU_Func   <= 4'b0000;
                illegal_op <= 1'b1;
            end
        end else begin
            if (w_issue) begin
                valid_out <= 1'b0;
            end else begin
                valid_out <= valid_out;
            end
            illegal_op <= 1'b0;
        end
    end

    // Debug counters. An output handshake still counts during a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count   <= {CNT_W{1'b0}};
            illegal_count <= {CNT_W{1'b0}};
        end else begin
            if (w_issue) begin
                issue_count <= sat_inc(issue_count);
            end else begin
                issue_count <= issue_count;
            end
            if (!flush && w_accept && !w_legal) begin
                illegal_count <= sat_inc(illegal_count);
            end else begin
                illegal_count <= illegal_count;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  func;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic          ready_in;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic [15:0]   imm16;
    logic          flush;
    logic          valid_out;
    logic          ready_out;
    logic [31:0]   In1;
    logic [31:0]   In2;
    logic [3:0]    ALU_Func;
    logic          illegal_op;
    logic [CW-1:0] issue_count;
    logic [CW-1:0] illegal_count;

    alu_issue_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
        .imm16(imm16), .flush(flush), .valid_out(valid_out), .ready_out(ready_out),
        .In1(In1), .In2(In2), .ALU_Func(ALU_Func), .illegal_op(illegal_op),
        .issue_count(issue_count), .illegal_count(illegal_count)
    );

    int      n_chk = 0;
    int      n_err = 0;
    exp_t    exp_q[$];
    exp_t    pend_exp;
    logic    pend_legal;
    logic [CW-1:0] n_issued;
    exp_t    cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic present(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] imm, input logic lg,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [3:0] ef);
        opcode     = op;
        funct      = fn;
        rs_data    = rs;
        rt_data    = rt;
        imm16      = imm;
        pend_legal = lg;
        pend_exp.in1  = e1;
        pend_exp.in2  = e2;
        pend_exp.func = ef;
        valid_in   = 1'b1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic lg,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [3:0] ef);
        present(op, fn, rs, rt, imm, lg, e1, e2, ef);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Scoreboard push: a legal op accepted this cycle is expected downstream.
    always @(negedge clk) begin
        if (!rst && valid_in && ready_in && !flush && pend_legal) begin
            exp_q.push_back(pend_exp);
        end
    end

    // Monitor: compare each downstream handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_issued = '0;
        end else begin
            check("issue_count", 32'(issue_count), 32'(n_issued));
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("In1", In1, cur.in1);
                    check("In2", In2, cur.in2);
                    check("ALU_Func", 32'(ALU_Func), 32'(cur.func));
                end
                if (n_issued != CMAX) n_issued = n_issued + 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0;
        opcode = 6'h00; funct = 6'h00; rs_data = 32'h0; rt_data = 32'h0; imm16 = 16'h0;
        pend_legal = 1'b0; pend_exp = '0; n_issued = '0;
        #1;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_ALU_Func", 32'(ALU_Func), 32'd0);
        check("rst_illegal_cnt", 32'(illegal_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        ready_out = 1'b1;
        @(posedge clk);
        #1;

        // R-type sub
        issue(6'h00, 6'h22, 32'd7, 32'd3, 16'h0, 1'b1, 32'd7, 32'd3, 4'b1100);
        @(negedge clk);
        check("sub_valid_out", 32'(valid_out), 32'd1);
        @(negedge clk);
        check("sub_issue_count", 32'(issue_count), 32'd1);
        @(posedge clk);
        #1;

        // Immediates and the rest of the decode table, back to back
        issue(6'h08, 6'h00, 32'd5, 32'd9, 16'hFFFF, 1'b1, 32'd5, 32'hFFFF_FFFF, 4'b0100);
        issue(6'h0D, 6'h00, 32'd5, 32'd9, 16'hFFFF, 1'b1, 32'd5, 32'h0000_FFFF, 4'b0001);
        issue(6'h0F, 6'h00, 32'hAAAA, 32'd9, 16'h1234, 1'b1, 32'd0, 32'h1234_0000, 4'b0100);
        issue(6'h0A, 6'h00, 32'd1, 32'd2, 16'h8000, 1'b1, 32'd1, 32'hFFFF_8000, 4'b1101);
        issue(6'h0C, 6'h00, 32'd3, 32'd2, 16'h80F0, 1'b1, 32'd3, 32'h0000_80F0, 4'b0000);
        issue(6'h0E, 6'h00, 32'd4, 32'd2, 16'h8001, 1'b1, 32'd4, 32'h0000_8001, 4'b0010);
        issue(6'h2B, 6'h00, 32'h100, 32'd2, 16'h0004, 1'b1, 32'h100, 32'h4, 4'b0100);
        issue(6'h04, 6'h3F, 32'h10, 32'h20, 16'h5555, 1'b1, 32'h10, 32'h20, 4'b1100);
        issue(6'h00, 6'h2A, 32'h11, 32'h22, 16'h0, 1'b1, 32'h11, 32'h22, 4'b1101);
        issue(6'h00, 6'h24, 32'h33, 32'h44, 16'h0, 1'b1, 32'h33, 32'h44, 4'b0000);
        issue(6'h00, 6'h25, 32'h55, 32'h66, 16'h0, 1'b1, 32'h55, 32'h66, 4'b0001);
        issue(6'h00, 6'h26, 32'h77, 32'h88, 16'h0, 1'b1, 32'h77, 32'h88, 4'b0010);
        issue(6'h00, 6'h21, 32'h99, 32'hAA, 16'h0, 1'b1, 32'h99, 32'hAA, 4'b0100);
        issue(6'h00, 6'h23, 32'hBB, 32'hCC, 16'h0, 1'b1, 32'hBB, 32'hCC, 4'b1100);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: A held for 3 cycles while B waits, then no bubble
        ready_out = 1'b0;
        present(6'h00, 6'h20, 32'hA1, 32'hA2, 16'h0, 1'b1, 32'hA1, 32'hA2, 4'b0100);
        @(posedge clk);
        #1;
        present(6'h00, 6'h22, 32'hB1, 32'hB2, 16'h0, 1'b1, 32'hB1, 32'hB2, 4'b1100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready_in", 32'(ready_in), 32'd0);
            check("hold_valid_out", 32'(valid_out), 32'd1);
            check("hold_In1", In1, 32'hA1);
            check("hold_ALU_Func", 32'(ALU_Func), 32'(4'b0100));
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        @(negedge clk);
        check("release_ready_in", 32'(ready_in), 32'd1);
        @(posedge clk);
        #1;
        present(6'h00, 6'h26, 32'hC1, 32'hC2, 16'h0, 1'b1, 32'hC1, 32'hC2, 4'b0010);
        @(negedge clk);
        check("b2b_valid_B", 32'(valid_out), 32'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("b2b_valid_C", 32'(valid_out), 32'd1);
        @(posedge clk);
        #1;

        // Reset between edges with an op stuck in the output register
        ready_out = 1'b0;
        issue(6'h00, 6'h20, 32'hD1, 32'hD2, 16'h0, 1'b1, 32'hD1, 32'hD2, 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid_out", 32'(valid_out), 32'd0);
        check("mid_rst_In1", In1, 32'd0);
        check("mid_rst_In2", In2, 32'd0);
        check("mid_rst_ALU_Func", 32'(ALU_Func), 32'd0);
        check("mid_rst_issue_cnt", 32'(issue_count), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("post_rst_ready_in", 32'(ready_in), 32'd1);
        ready_out = 1'b1;
        @(posedge clk);
        #1;

        // Illegal NOR, then flush discards a valid input
        present(6'h00, 6'h27, 32'hE1, 32'hE2, 16'h0, 1'b0, 32'h0, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        flush = 1'b1;
        present(6'h00, 6'h20, 32'hF1, 32'hF2, 16'h0, 1'b1, 32'hF1, 32'hF2, 4'b0100);
        @(negedge clk);
        check("illegal_op_pulse", 32'(illegal_op), 32'd1);
        check("illegal_valid_out", 32'(valid_out), 32'd0);
        check("illegal_ALU_Func", 32'(ALU_Func), 32'd0);
        check("illegal_count_1", 32'(illegal_count), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("flush_valid_out", 32'(valid_out), 32'd0);
        check("illegal_op_clear", 32'(illegal_op), 32'd0);
        check("flush_illegal_cnt", 32'(illegal_count), 32'd1);
        @(posedge clk);
        #1;

        // Flush during an output handshake: the old op still counts
        issue(6'h00, 6'h25, 32'h12, 32'h34, 16'h0, 1'b1, 32'h12, 32'h34, 4'b0001);
        flush = 1'b1;
        present(6'h00, 6'h24, 32'h56, 32'h78, 16'h0, 1'b1, 32'h56, 32'h78, 4'b0000);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("flush_hs_valid_out", 32'(valid_out), 32'd0);
        check("flush_hs_issue_cnt", 32'(issue_count), 32'd1);
        @(posedge clk);
        #1;

        // Saturation of both counters
        for (int i = 0; i < 20; i++) begin
            issue(6'h3F, 6'h00, 32'(i), 32'd0, 16'h0, 1'b0, 32'h0, 32'h0, 4'b0000);
        end
        @(negedge clk);
        check("illegal_count_sat", 32'(illegal_count), 32'(CMAX));
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            issue(6'h09, 6'h00, 32'(i), 32'd0, 16'(i), 1'b1, 32'(i), 32'(i), 4'b0100);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("issue_count_sat", 32'(issue_count), 32'(CMAX));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
